// File: rtl/instr_sequencer_if.sv
// RX byte-stream and command/completion bundle between instr_sequencer (master) and its datapath (slave).
interface instr_sequencer_if #(
    parameter int BYTE_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 9,
    parameter int OPCODE_WIDTH = 3
);
    logic [BYTE_WIDTH-1:0]   rx_data;
    logic                    rx_empty;
    logic                    rx_re;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [OPCODE_WIDTH-1:0] cmd_op;
    logic [2:0]              cmd_flags;
    logic [ADDRESS_SIZE-1:0] cmd_addr;
    logic                    cmd_done;

    // A command transfers only in a cycle with cmd_valid and cmd_ready both high; op/flags/addr hold
    // while valid waits. rx_re pops the FWFT head in the same cycle and is never high while rx_empty.
    modport master (
        input  rx_data, rx_empty, cmd_ready, cmd_done,
        output rx_re, cmd_valid, cmd_op, cmd_flags, cmd_addr
    );

    modport slave (
        output rx_data, rx_empty, cmd_ready, cmd_done,
        input  rx_re, cmd_valid, cmd_op, cmd_flags, cmd_addr
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode/issue sequencer: assembles little-endian instructions from the RX FIFO and issues commands.
// Optional completion watchdog enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer #(
    parameter int BYTE_WIDTH     = 8,
    parameter int INSTR_BYTES    = 2,
    parameter int ADDRESS_SIZE   = 9,
    parameter int OPCODE_WIDTH   = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    instr_sequencer_if.master   bus,
    output logic                o_busy,
    output logic                o_halted,
    output logic                o_err,
    output logic [15:0]         o_retired,
    output logic [2:0]          o_dbg_state
);
    localparam int IW        = INSTR_BYTES * BYTE_WIDTH;
    localparam int EXT_BYTES = (ADDRESS_SIZE + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int EW        = EXT_BYTES * BYTE_WIDTH;
    localparam int MAXB      = (INSTR_BYTES > EXT_BYTES) ? INSTR_BYTES : EXT_BYTES;
    localparam int CW        = $clog2(MAXB + 1);

    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXT   = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_HALT  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_byte_cnt;
    logic [IW-1:0]           r_instr;
    logic [EW-1:0]           r_ext;
    logic                    r_cmd_valid;
    logic [OPCODE_WIDTH-1:0] r_cmd_op;
    logic [2:0]              r_cmd_flags;
    logic [ADDRESS_SIZE-1:0] r_cmd_addr;
    logic [15:0]             r_retired;

    logic [IW-1:0]           w_instr_next;
    logic [EW-1:0]           w_ext_next;
    logic [OPCODE_WIDTH-1:0] w_op;
    logic [2:0]              w_flags;
    logic [ADDRESS_SIZE-1:0] w_addr;
    logic                    w_fetch_done;
    logic                    w_pop;
    logic                    w_unused;

    // Bytes enter at the top and shift down, so the first byte popped lands in the lowest slot.
    assign w_instr_next = (r_instr >> BYTE_WIDTH) | (IW'(bus.rx_data) << (IW - BYTE_WIDTH));
    assign w_ext_next   = (r_ext >> BYTE_WIDTH) | (EW'(bus.rx_data) << (EW - BYTE_WIDTH));

    assign w_op         = r_instr[OPCODE_WIDTH-1:0];
    assign w_flags      = r_instr[OPCODE_WIDTH+2:OPCODE_WIDTH];
    assign w_addr       = r_instr[IW-1:IW-ADDRESS_SIZE];
    assign w_fetch_done = (r_byte_cnt == CW'(INSTR_BYTES));
    assign w_pop        = !bus.rx_empty && ((r_state == S_FETCH && !w_fetch_done) || r_state == S_EXT);

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;
    assign w_unused = ^{r_instr, r_ext, w_ext_next};
`else
    assign w_unused = ^{r_instr, r_ext, w_ext_next, (TIMEOUT_CYCLES > 0)};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= '0;
            r_instr     <= '0;
            r_ext       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= '0;
            r_cmd_flags <= '0;
            r_cmd_addr  <= '0;
            r_retired   <= '0;
`ifdef SEQ_TIMEOUT_EN
            r_wd        <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    // The cycle after the last byte lands is the decode cycle; no pop happens in it.
                    if (w_fetch_done) begin
                        r_byte_cnt <= '0;
                        if (w_op > OP_NOP) begin
                            r_state <= S_ERROR;
                        end else if (w_op == OP_NOP) begin
                            r_retired <= r_retired + 16'd1;
                        end else if (w_op == OP_HALT) begin
                            r_retired <= r_retired + 16'd1;
                            r_state   <= S_HALT;
                        end else begin
                            r_cmd_op    <= w_op;
                            r_cmd_flags <= w_flags;
                            if (w_op == OP_STORE && w_flags[0]) begin
                                r_state <= S_EXT;
                            end else begin
                                r_cmd_addr  <= w_addr;
                                r_cmd_valid <= 1'b1;
                                r_state     <= S_ISSUE;
                            end
                        end
                    end else if (w_pop) begin
                        r_instr    <= w_instr_next;
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                    end
                end
                S_EXT: begin
                    if (w_pop) begin
                        r_ext <= w_ext_next;
                        if (r_byte_cnt == CW'(EXT_BYTES - 1)) begin
                            r_byte_cnt  <= '0;
                            r_cmd_addr  <= w_ext_next[ADDRESS_SIZE-1:0];
                            r_cmd_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CW'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                        r_wd        <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus.cmd_done) begin
                        r_retired <= r_retired + 16'd1;
                        r_state   <= S_FETCH;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (r_wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
`endif
                end
                S_HALT, S_ERROR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_re     = w_pop;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_op    = r_cmd_op;
    assign bus.cmd_flags = r_cmd_flags;
    assign bus.cmd_addr  = r_cmd_addr;

    assign o_busy      = !(r_state == S_IDLE || r_state == S_HALT || r_state == S_ERROR);
    assign o_halted    = (r_state == S_HALT);
    assign o_err       = (r_state == S_ERROR);
    assign o_retired   = r_retired;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: reset, table of single instructions, directed multi-cycle sequences,
// randomized streams against a byte-stream reference model, and the watchdog when SEQ_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_instr_sequencer;
    localparam int BW = 8;
    localparam int IB = 2;
    localparam int AS = 9;
    localparam int OW = 3;
    localparam int TO = 1024;
    localparam int W  = OW + 3 + AS;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, halted, err;
    logic [15:0] retired;
    logic [2:0]  dbg_state;

    instr_sequencer_if #(.BYTE_WIDTH(BW), .ADDRESS_SIZE(AS), .OPCODE_WIDTH(OW)) bus ();

    instr_sequencer #(
        .BYTE_WIDTH(BW), .INSTR_BYTES(IB), .ADDRESS_SIZE(AS), .OPCODE_WIDTH(OW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .i_start(start), .bus(bus),
        .o_busy(busy), .o_halted(halted), .o_err(err), .o_retired(retired), .o_dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
        $fatal(1, "global timeout");
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]   fifo_q[$];
    logic [7:0]   stream[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];

    int   pop_cnt = 0;
    int   hs_cnt  = 0;
    int   re_viol = 0;
    int   valid_viol = 0;
    bit   auto_resp = 0;
    int   ready_pct = 100;
    int   stall_pct = 0;
    int   done_cd = -1;

    logic          s_valid, s_ready, s_re, s_err;
    logic [OW-1:0] s_op;
    logic [2:0]    s_fl;
    logic [AS-1:0] s_ad;

    typedef struct {
        logic [7:0] b0, b1;
        bit         ext;
        logic [7:0] e0, e1;
        bit         is_cmd;
        int         op, fl, ad;
    } vec_t;
    vec_t vt[8];

    function automatic logic [W-1:0] pack(input int op, input int fl, input int ad);
        logic [W-1:0] v;
        v = {3'(op), 3'(fl), 9'(ad)};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // driver: one clock cycle, entered and left at the falling edge
    task automatic tick();
        logic popped;
        bus.rx_empty = ($urandom_range(0, 99) < stall_pct) || (fifo_q.size() == 0);
        bus.rx_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        if (auto_resp) begin
            bus.cmd_ready = ($urandom_range(0, 99) < ready_pct);
            bus.cmd_done  = 1'b0;
            if (done_cd == 0) begin
                bus.cmd_done = 1'b1;
                done_cd = -1;
            end else if (done_cd > 0) begin
                done_cd--;
            end
        end
        #1;
        s_valid = bus.cmd_valid; s_ready = bus.cmd_ready; s_re = bus.rx_re; s_err = err;
        s_op = bus.cmd_op; s_fl = bus.cmd_flags; s_ad = bus.cmd_addr;
        if (bus.rx_re && bus.rx_empty) re_viol++;
        if (bus.cmd_valid && (halted || err)) valid_viol++;
        popped = bus.rx_re;
        if (bus.cmd_valid && bus.cmd_ready) begin
            got_q.push_back({bus.cmd_op, bus.cmd_flags, bus.cmd_addr});
            hs_cnt++;
            if (auto_resp) done_cd = $urandom_range(0, 4);
        end
        @(posedge clk);
        if (popped) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        fifo_q.delete();
        got_q.delete();
        start = 1'b0;
        rst = 1'b1;
        auto_resp = 0;
        stall_pct = 0;
        done_cd = -1;
        bus.cmd_ready = 1'b0;
        bus.cmd_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push2(input logic [7:0] a, input logic [7:0] b);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
    endtask

    task automatic run_until_retired(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (retired != 16'(target) && n < budget) begin
            tick();
            n++;
        end
        check(name, retired, target);
    endtask

    task automatic expect_cmd(input string name, input int op, input int fl, input int ad);
        check({name, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) check(name, got_q.pop_front(), pack(op, fl, ad));
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        tick();
        while (!s_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, s_valid, 1);
    endtask

    // reference model: walk the byte stream instruction by instruction
    task automatic model(input logic [7:0] s[$], output int ret, output int pops, output bit hlt, output bit er);
        int i, op, fl;
        logic [15:0] ins, ext;
        exp_q.delete();
        ret = 0; hlt = 0; er = 0; i = 0;
        while (i + 2 <= s.size()) begin
            ins = {s[i+1], s[i]};
            i += 2;
            op = int'(ins % 16'd8);
            fl = int'((ins / 16'd8) % 16'd8);
            if (op >= 6) begin er = 1; break; end
            if (op == 5) begin ret++; continue; end
            if (op == 4) begin ret++; hlt = 1; break; end
            if (op == 0 && (fl % 2) == 1) begin
                ext = {s[i+1], s[i]};
                i += 2;
                exp_q.push_back(pack(op, fl, int'(ext % 16'd512)));
            end else begin
                exp_q.push_back(pack(op, fl, int'(ins / 16'd128)));
            end
            ret++;
        end
        pops = i;
    endtask

    initial begin
        int lat, stable_bad, acc_re, acc_valid, p0, n, hs0;
        int e_ret, e_pops, nins, op;
        bit e_h, e_e;
        logic [15:0] ins;

        rst = 1'b1; start = 1'b0;
        bus.rx_empty = 1'b1; bus.rx_data = '0; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0;
        @(negedge clk);

        // reset state
        do_reset();
        check("rst_rx_re", bus.rx_re, 0);
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_fields", {bus.cmd_op, bus.cmd_flags, bus.cmd_addr}, 0);
        check("rst_status", {busy, halted, err}, 0);
        check("rst_retired", retired, 0);

        // FETCH op 1: latency, handshake on first ISSUE cycle, done three cycles later
        push2(8'h41, 8'h03);
        tick(); tick();
        check("idle_no_pop", pop_cnt, 0);
        kick();
        bus.cmd_ready = 1'b1;
        lat = 0;
        tick();
        while (!s_valid && lat < 20) begin
            lat++;
            tick();
        end
        check("fetch_to_valid_cycles", lat, 3);
        check("first_issue_handshake", hs_cnt, 1);
        bus.cmd_ready = 1'b0;
        tick(); tick();
        check("retired_before_done", retired, 0);
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        check("retired_after_done", retired, 1);
        check("busy_back_in_fetch", busy, 1);
        expect_cmd("fetch_cmd", 1, 0, 6);

        // RUN with ready held low: fields stable, cmd_done ignored outside WAIT, single transfer
        push2(8'hBA, 8'hFF);
        wait_valid("run_valid_seen", 10);
        bus.cmd_done = 1'b1;
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!s_valid || s_op != 3'd2 || s_fl != 3'd7 || s_ad != 9'h1FF) stable_bad++;
        end
        bus.cmd_done = 1'b0;
        check("hold_stable", stable_bad, 0);
        check("done_ignored_in_issue", retired, 1);
        check("no_transfer_while_not_ready", hs_cnt, 1);
        bus.cmd_ready = 1'b1;
        tick();
        bus.cmd_ready = 1'b0;
        tick(); tick(); tick();
        check("single_transfer", hs_cnt, 2);
        expect_cmd("run_cmd", 2, 7, 9'h1FF);
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        check("run_retired", retired, 2);

        // STORE with extended operand, RX stalls interleaved
        auto_resp = 1; ready_pct = 100; stall_pct = 50;
        p0 = pop_cnt;
        push2(8'h08, 8'h00);
        push2(8'h34, 8'h01);
        run_until_retired("store_ext_retired", 3, 200);
        stall_pct = 0;
        check("store_ext_pops", pop_cnt - p0, 4);
        expect_cmd("store_ext_cmd", 0, 1, 9'h134);

        // NOP then HALT: nothing issued, trailing bytes stay in the FIFO, start ignored
        hs0 = hs_cnt;
        push2(8'h05, 8'h00);
        push2(8'h04, 8'h00);
        push2(8'h41, 8'h03);
        n = 0;
        while (!halted && n < 60) begin tick(); n++; end
        check("halt_reached", halted, 1);
        check("halt_retired", retired, 5);
        check("halt_no_cmd", hs_cnt - hs0, 0);
        check("halt_status", {busy, err}, 0);
        start = 1'b1;
        acc_re = 0;
        for (int i = 0; i < 6; i++) begin tick(); acc_re += s_re; end
        start = 1'b0;
        check("halt_no_pops", acc_re, 0);
        check("halt_fifo_left", fifo_q.size(), 2);
        check("halt_sticky", halted, 1);

        // illegal opcode: sticky error until reset
        do_reset();
        check("rst_clears_halt", {halted, retired}, 0);
        kick();
        hs0 = hs_cnt;
        push2(8'h07, 8'h00);
        push2(8'h41, 8'h03);
        n = 0;
        while (!err && n < 40) begin tick(); n++; end
        check("illegal_err", err, 1);
        check("illegal_busy", busy, 0);
        start = 1'b1; bus.cmd_ready = 1'b1;
        acc_re = 0; acc_valid = 0;
        for (int i = 0; i < 6; i++) begin tick(); acc_re += s_re; acc_valid += s_valid; end
        start = 1'b0; bus.cmd_ready = 1'b0;
        check("err_no_pops", acc_re, 0);
        check("err_no_cmd", acc_valid + hs_cnt - hs0, 0);
        check("err_fifo_left", fifo_q.size(), 2);
        do_reset();
        check("rst_clears_err", err, 0);

        // reset after the first byte: next byte is a low byte again
        kick();
        fifo_q.push_back(8'h99);
        n = 0;
        while (fifo_q.size() != 0 && n < 10) begin tick(); n++; end
        check("partial_byte_popped", fifo_q.size(), 0);
        do_reset();
        kick();
        auto_resp = 1; ready_pct = 100;
        push2(8'h41, 8'h03);
        run_until_retired("after_partial_retired", 1, 40);
        expect_cmd("after_partial_cmd", 1, 0, 6);

        // reset while a command waits for ready
        auto_resp = 0; bus.cmd_ready = 1'b0;
        push2(8'hBA, 8'hFF);
        wait_valid("pre_rst_valid", 10);
        do_reset();
        check("rst_mid_hs_valid", bus.cmd_valid, 0);
        check("rst_mid_hs_fields", {bus.cmd_op, bus.cmd_flags, bus.cmd_addr}, 0);
        check("rst_mid_hs_busy", busy, 0);

        // table of single instructions
        vt[0] = '{8'h41, 8'h03, 0, 8'h00, 8'h00, 1, 1, 0, 6};
        vt[1] = '{8'hBA, 8'hFF, 0, 8'h00, 8'h00, 1, 2, 7, 9'h1FF};
        vt[2] = '{8'h03, 8'h80, 0, 8'h00, 8'h00, 1, 3, 0, 9'h100};
        vt[3] = '{8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0};
        vt[4] = '{8'h08, 8'h00, 1, 8'h34, 8'h01, 1, 0, 1, 9'h134};
        vt[5] = '{8'h18, 8'hA5, 1, 8'hFF, 8'hFF, 1, 0, 3, 9'h1FF};
        vt[6] = '{8'h2D, 8'h7F, 0, 8'h00, 8'h00, 0, 5, 5, 0};
        vt[7] = '{8'h31, 8'h01, 0, 8'h00, 8'h00, 1, 1, 6, 2};
        kick();
        auto_resp = 1; ready_pct = 100; stall_pct = 0;
        for (int i = 0; i < 8; i++) begin
            push2(vt[i].b0, vt[i].b1);
            if (vt[i].ext) push2(vt[i].e0, vt[i].e1);
            run_until_retired($sformatf("tbl%0d_retired", i), i + 1, 60);
            check($sformatf("tbl%0d_cmd_count", i), got_q.size(), vt[i].is_cmd);
            if (got_q.size() > 0)
                check($sformatf("tbl%0d_cmd", i), got_q.pop_front(), pack(vt[i].op, vt[i].fl, vt[i].ad));
        end

        // randomized streams: run 0 ends in HALT, run 1 in an illegal opcode, run 2 just drains
        for (int r = 0; r < 3; r++) begin
            do_reset();
            kick();
            auto_resp = 1; ready_pct = 60; stall_pct = 25;
            stream.delete();
            nins = $urandom_range(8, 20);
            for (int k = 0; k < nins; k++) begin
                op = $urandom_range(0, 4);
                if (op == 4) op = 5;
                ins = 16'($urandom_range(0, 65535));
                ins = (ins & 16'hFFF8) | 16'(op);
                stream.push_back(ins[7:0]);
                stream.push_back(ins[15:8]);
                if (op == 0 && ins[3]) begin
                    stream.push_back(8'($urandom_range(0, 255)));
                    stream.push_back(8'($urandom_range(0, 255)));
                end
            end
            if (r < 2) begin
                ins = 16'($urandom_range(0, 65535));
                ins = (ins & 16'hFFF8) | ((r == 0) ? 16'd4 : 16'($urandom_range(6, 7)));
                stream.push_back(ins[7:0]);
                stream.push_back(ins[15:8]);
                stream.push_back(8'($urandom_range(0, 255)));
                stream.push_back(8'($urandom_range(0, 255)));
            end
            model(stream, e_ret, e_pops, e_h, e_e);
            got_q.delete();
            p0 = pop_cnt;
            foreach (stream[k]) fifo_q.push_back(stream[k]);
            n = 0;
            while (n < 4000 && !(retired == 16'(e_ret) && halted == e_h && err == e_e
                                 && (pop_cnt - p0) == e_pops)) begin
                tick();
                n++;
            end
            for (int k = 0; k < 4; k++) tick();
            check($sformatf("rnd%0d_retired", r), retired, e_ret);
            check($sformatf("rnd%0d_halted", r), halted, e_h);
            check($sformatf("rnd%0d_err", r), err, e_e);
            check($sformatf("rnd%0d_pops", r), pop_cnt - p0, e_pops);
            check($sformatf("rnd%0d_cmd_count", r), got_q.size(), exp_q.size());
            while (got_q.size() > 0 && exp_q.size() > 0)
                check($sformatf("rnd%0d_cmd", r), got_q.pop_front(), exp_q.pop_front());
        end
        stall_pct = 0;

`ifdef SEQ_TIMEOUT_EN
        // watchdog: done withheld for the whole window, then done on the final cycle
        do_reset();
        kick();
        bus.cmd_ready = 1'b1;
        push2(8'h03, 8'h00);
        wait_valid("wd_valid", 10);
        bus.cmd_ready = 1'b0;
        for (int j = 0; j < TO; j++) tick();
        check("wd_no_err_in_window", s_err, 0);
        check("wd_err_after_window", err, 1);
        do_reset();
        kick();
        bus.cmd_ready = 1'b1;
        push2(8'h03, 8'h00);
        wait_valid("wd2_valid", 10);
        bus.cmd_ready = 1'b0;
        for (int j = 0; j < TO - 1; j++) tick();
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        tick(); tick();
        check("wd_done_last_cycle_no_err", err, 0);
        check("wd_done_last_cycle_retired", retired, 1);
`endif

        check("rx_re_while_empty", re_viol, 0);
        check("cmd_valid_after_halt_or_err", valid_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Parametrised instruction fetch/decode/issue sequencer for the uTPU control path. It consumes a byte stream from the RX FIFO and assembles multi-byte instructions. An optional extended-address operand follows STORE instructions. The sequencer decodes opcode, flags and address, then issues one command at a time to the buffer/compute datapath over a valid/ready handshake and waits for completion. It replaces the hard-coded 2-byte fetch FSM in the top-level controller and adds configurable instruction width, illegal-opcode trapping, a completion watchdog and a retired-instruction count.

## Interface
- BYTE_WIDTH, 8, width of one RX FIFO entry
- INSTR_BYTES, 2, bytes per instruction; INSTR_BYTES*BYTE_WIDTH >= OPCODE_WIDTH+3+ADDRESS_SIZE
- ADDRESS_SIZE, 9, buffer address width
- OPCODE_WIDTH, 3, opcode field width (>=3)
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before error (only with SEQ_TIMEOUT_EN)
- Derived: EXT_BYTES = ceil(ADDRESS_SIZE/BYTE_WIDTH); IW = INSTR_BYTES*BYTE_WIDTH
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- rx_data  in  BYTE_WIDTH  FIFO head (first-word-fall-through, valid while ~rx_empty)
- rx_empty  in  1  FIFO empty
- rx_re  out  1  pop FIFO head this cycle
- cmd_valid  out  1  command presented
- cmd_ready  in  1  datapath accepts command
- cmd_op  out  OPCODE_WIDTH  decoded opcode
- cmd_flags  out  3  instr[OPCODE_WIDTH+2:OPCODE_WIDTH]
- cmd_addr  out  ADDRESS_SIZE  instr[IW-1:IW-ADDRESS_SIZE], or the extended operand
- cmd_done  in  1  datapath finished current command
- busy  out  1  state not IDLE/HALT/ERROR
- halted  out  1  HALT executed
- err  out  1  illegal opcode or timeout
- retired  out  16  count of completed instructions, NOP and HALT included, wraps at 0xFFFF

## Operation
- Opcodes: 0 STORE, 1 FETCH, 2 RUN, 3 LOAD, 4 HALT, 5 NOP, all others illegal.
- States: IDLE, FETCH, EXT, ISSUE, WAIT, HALT, ERROR.
- IDLE: outputs quiescent; go to FETCH when start=1.
- FETCH: when ~rx_empty, assert rx_re and capture rx_data into byte slot byte_cnt, little-endian (first byte = instr[BYTE_WIDTH-1:0]). byte_cnt increments. After the byte INSTR_BYTES-1 capture, decode on the next cycle:
  - illegal opcode → ERROR
  - NOP → retired++, return to FETCH
  - HALT → retired++, go to HALT
  - STORE with flags[0]=1 → EXT
  - anything else → ISSUE
- EXT: pop EXT_BYTES bytes the same way, little-endian, into an operand register. cmd_addr = operand[ADDRESS_SIZE-1:0]; upper bits are discarded. Then go to ISSUE.
- ISSUE: cmd_valid=1. cmd_op, cmd_flags and cmd_addr are stable while valid. On cmd_valid&cmd_ready go to WAIT on the next cycle.
- WAIT: cmd_done=1 → retired++, go to FETCH. cmd_done outside WAIT is ignored.
- HALT: halted=1, rx_re=0. Sticky until rst; start is ignored.
- ERROR: err=1, no pops, no commands. Sticky until rst.
- rx_re is never asserted when rx_empty=1, nor outside FETCH/EXT.

## Timing
- Reset (any state, including mid-fetch or mid-handshake): next cycle state=IDLE. byte_cnt=0, partial instruction discarded. rx_re=0, cmd_valid=0, cmd_op/cmd_flags/cmd_addr=0, busy=0, halted=0, err=0, retired=0. Watchdog cleared.
- One byte per cycle at most. rx_re is combinational from state and rx_empty.
- rx_empty stalls: byte_cnt holds; no timeout applies in FETCH/EXT.
- Latency, non-ext instruction with bytes always available: INSTR_BYTES pop cycles, 1 decode cycle, then cmd_valid. With ready=1 the handshake completes in the first ISSUE cycle.
- Decode-to-FETCH for NOP takes 1 cycle; pops resume the following cycle.
- cmd_ready asserted before cmd_valid is permitted; the transfer occurs only in a cycle with both high.
- Earliest accepted cmd_done is the cycle after the handshake.

## Configuration
- SEQ_TIMEOUT_EN defined: a watchdog counts WAIT cycles from 0. If the count reaches TIMEOUT_CYCLES-1 without cmd_done, the next state is ERROR. The counter clears on entering WAIT. cmd_done in the final cycle wins over the timeout.
- Undefined: no watchdog logic; WAIT persists indefinitely. TIMEOUT_CYCLES is unused.

## Test plan
- start, bytes 0x41,0x03 → cmd_valid with cmd_op=1, cmd_flags=0, cmd_addr=6; ready=1, done 3 cycles later → retired=1, back in FETCH.
- Bytes 0xBA,0xFF with cmd_ready held low 5 cycles → cmd_valid stays high with cmd_op=2, flags=7, addr=0x1FF unchanged; one transfer when ready rises.
- Bytes 0x08,0x00,0x34,0x01 → STORE, flags=1, cmd_addr=0x134; exactly 4 rx_re pulses. rx_empty inserted between bytes stalls without corruption.
- Bytes 0x05,0x00 then 0x04,0x00 → no cmd_valid, retired=2, halted=1; further bytes never popped.
- Bytes 0x07,0x00 → err=1, no cmd_valid, rx_re stays 0; rst clears err to 0.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=1024: LOAD 0x03,0x00 accepted, done withheld → err=1 after 1024 WAIT cycles. Done on cycle 1024 → no err. rst after the first byte of an instruction → the next byte is treated as a low byte.
